// File: rtl/regbank_write_arbiter_pkg.sv
// regbank_pkg: shared widths, the holding-register entry type and small
// helpers used by the register-bank write arbiter.
//   REG_ADDR_W / REG_DATA_W / NUM_REGS : register bank geometry
//   AGE_W      : width of the wrapping accept-order stamp kept per entry
//   NUM_PORTS  : writeback sources sharing the bank write port
package regbank_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam int NUM_REGS   = 32;
  localparam int AGE_W      = 3;
  localparam int NUM_PORTS  = 2;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
    logic [AGE_W-1:0]      age;
  } wb_entry_t;

  typedef struct packed {
    logic                  hit;
    logic [REG_DATA_W-1:0] data;
  } fwd_rsp_t;

  // Stamps come from a wrapping counter. An entry can only stay held while
  // at most a couple of newer accepts happen, so the live distance between
  // two stamps is small and a signed wrap-around compare is exact.
  function automatic logic is_older(input logic [AGE_W-1:0] a,
                                    input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] d;
    d = b - a;
    return (d != '0) && !d[AGE_W-1];
  endfunction

  // Match held entries against a read address; x0 never hits. When both
  // entries target the address, the younger one carries the newest value.
  function automatic fwd_rsp_t fwd_lookup(input wb_entry_t e0,
                                          input wb_entry_t e1,
                                          input logic [REG_ADDR_W-1:0] addr);
    logic     m0, m1;
    fwd_rsp_t r;
    m0    = e0.valid && (e0.rd == addr) && (addr != '0);
    m1    = e1.valid && (e1.rd == addr) && (addr != '0);
    r.hit = m0 | m1;
    if (m0 && m1)  r.data = is_older(e0.age, e1.age) ? e1.data : e0.data;
    else if (m0)   r.data = e0.data;
    else if (m1)   r.data = e1.data;
    else           r.data = '0;
    return r;
  endfunction
endpackage

// File: rtl/regbank_write_arbiter_if.sv
// regbank_write_arbiter_if: bundle of the two writeback handshakes, the bank
// write port, the busy bitmap and the forwarding lookup.
//   slave  : arbiter side (takes wb*/fwd_addr*, drives ready, rf_*, busy, fwd_*)
//   master : requester / consumer side
interface regbank_write_arbiter_if;
  import regbank_pkg::*;

  logic                  wb0_valid, wb0_ready;
  logic [REG_ADDR_W-1:0] wb0_rd;
  logic [REG_DATA_W-1:0] wb0_data;
  logic                  wb1_valid, wb1_ready;
  logic [REG_ADDR_W-1:0] wb1_rd;
  logic [REG_DATA_W-1:0] wb1_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [REG_DATA_W-1:0] rf_wdata;
  logic [NUM_REGS-1:0]   busy;
  logic [REG_ADDR_W-1:0] fwd_addr1, fwd_addr2;
  logic                  fwd_hit1, fwd_hit2;
  logic [REG_DATA_W-1:0] fwd_data1, fwd_data2;

  modport slave (
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
           fwd_addr1, fwd_addr2,
    output wb0_ready, wb1_ready, rf_we, rf_waddr, rf_wdata, busy,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

  modport master (
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
           fwd_addr1, fwd_addr2,
    input  wb0_ready, wb1_ready, rf_we, rf_waddr, rf_wdata, busy,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/regbank_write_arbiter_wb_hold_slot.sv
// wb_hold_slot: one-entry holding register for a writeback source.
//   clk, rst_n         : clock, async active-low reset (drops the entry)
//   in_valid/in_ready  : source handshake; ready while empty or draining
//   in_rd/in_data      : destination register and result
//   in_age             : accept-order stamp captured with the entry
//   grant              : arbiter drains the entry at the next edge
//   entry              : current holding-register contents
module wb_hold_slot
  import regbank_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_DATA_W-1:0] in_data,
  input  logic [AGE_W-1:0]      in_age,
  input  logic                  grant,
  output wb_entry_t             entry
);
  logic accept;

  // A draining entry frees the slot in the same edge, so back-to-back accepts work.
  assign in_ready = !entry.valid || grant;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
    end else if (accept) begin
      entry.valid <= 1'b1;
      entry.rd    <= in_rd;
      entry.data  <= in_data;
      entry.age   <= in_age;
    end else if (grant) begin
      entry.valid <= 1'b0;
    end
  end
endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: shares the register bank write port between the
// pipeline writeback (port 0) and the memory/multicycle unit (port 1).
//   clk, rst_n : clock, async active-low reset
//   bus        : regbank_write_arbiter_if.slave (handshakes, rf_*, busy, fwd_*)
// Build option: RWARB_FWD_EN enables the forwarding lookup; without it the
// fwd_hit*/fwd_data* outputs are tied to zero.
module regbank_write_arbiter
  import regbank_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  regbank_write_arbiter_if.slave   bus
);
  logic [NUM_PORTS-1:0]                 in_valid, in_ready, grant, acc;
  logic [NUM_PORTS-1:0][REG_ADDR_W-1:0] in_rd;
  logic [NUM_PORTS-1:0][REG_DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0][AGE_W-1:0]      in_age;
  wb_entry_t [NUM_PORTS-1:0]            hold;
  logic [AGE_W-1:0]                     age_ctr;
  logic                                 last_gnt;
  logic [REG_ADDR_W-1:0]                sel_rd;
  logic [REG_DATA_W-1:0]                sel_data;
  logic [NUM_REGS-1:0]                  busy_v;

  assign in_valid = {bus.wb1_valid, bus.wb0_valid};
  assign in_rd    = {bus.wb1_rd,    bus.wb0_rd};
  assign in_data  = {bus.wb1_data,  bus.wb0_data};
  assign bus.wb0_ready = in_ready[0];
  assign bus.wb1_ready = in_ready[1];
  assign acc = in_valid & in_ready;

  // Same-cycle accepts: port 0 takes the lower stamp, i.e. it is older.
  assign in_age[0] = age_ctr;
  assign in_age[1] = age_ctr + AGE_W'(acc[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_ctr <= '0;
    else        age_ctr <= age_ctr + AGE_W'(acc[0]) + AGE_W'(acc[1]);
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
    wb_hold_slot u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[p]),
      .in_ready (in_ready[p]),
      .in_rd    (in_rd[p]),
      .in_data  (in_data[p]),
      .in_age   (in_age[p]),
      .grant    (grant[p]),
      .entry    (hold[p])
    );
  end

  // Same destination: age order keeps the bank's final value correct.
  // Different destinations: alternate, so a loser waits one cycle at most.
  always_comb begin
    grant = '0;
    if (hold[0].valid && hold[1].valid) begin
      if (hold[0].rd == hold[1].rd)
        grant = is_older(hold[0].age, hold[1].age) ? 2'b01 : 2'b10;
      else
        grant = last_gnt ? 2'b01 : 2'b10;
    end else begin
      grant = {hold[1].valid, hold[0].valid};
    end
  end

  // Reset to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_gnt <= 1'b1;
    else if (|grant) last_gnt <= grant[1];
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    if (grant[0]) begin
      sel_rd   = hold[0].rd;
      sel_data = hold[0].data;
    end else if (grant[1]) begin
      sel_rd   = hold[1].rd;
      sel_data = hold[1].data;
    end
  end

  // An x0 entry is still granted and drains, it just never writes.
  assign bus.rf_we    = (|grant) && (sel_rd != '0);
  assign bus.rf_waddr = sel_rd;
  assign bus.rf_wdata = sel_data;

  always_comb begin
    busy_v = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (hold[p].valid) busy_v[hold[p].rd] = 1'b1;
    busy_v[0] = 1'b0;
  end
  assign bus.busy = busy_v;

`ifdef RWARB_FWD_EN
  fwd_rsp_t fwd1, fwd2;
  assign fwd1 = fwd_lookup(hold[0], hold[1], bus.fwd_addr1);
  assign fwd2 = fwd_lookup(hold[0], hold[1], bus.fwd_addr2);
  assign bus.fwd_hit1  = fwd1.hit;
  assign bus.fwd_data1 = fwd1.data;
  assign bus.fwd_hit2  = fwd2.hit;
  assign bus.fwd_data2 = fwd2.data;
`else
  logic unused_fwd;
  assign unused_fwd    = ^{bus.fwd_addr1, bus.fwd_addr2};
  assign bus.fwd_hit1  = 1'b0;
  assign bus.fwd_data1 = '0;
  assign bus.fwd_hit2  = 1'b0;
  assign bus.fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_regbank_write_arbiter.sv
module tb_regbank_write_arbiter;
  import regbank_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regbank_write_arbiter_if bus();
  regbank_write_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef RWARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] rd0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [63:0] d1,
                       input logic [4:0] fa1, input logic [4:0] fa2);
    bus.wb0_valid = v0; bus.wb0_rd = rd0; bus.wb0_data = d0;
    bus.wb1_valid = v1; bus.wb1_rd = rd1; bus.wb1_data = d1;
    bus.fwd_addr1 = fa1; bus.fwd_addr2 = fa2;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [31:0] busy,
                         input logic r0, input logic r1,
                         input logic h1, input logic [63:0] f1,
                         input logic h2, input logic [63:0] f2);
    chk({tag, ".rf_we"},    bus.rf_we,     we);
    chk({tag, ".rf_waddr"}, bus.rf_waddr,  wa);
    chk({tag, ".rf_wdata"}, bus.rf_wdata,  wd);
    chk({tag, ".busy"},     bus.busy,      busy);
    chk({tag, ".wb0_ready"}, bus.wb0_ready, r0);
    chk({tag, ".wb1_ready"}, bus.wb1_ready, r1);
    chk({tag, ".fwd_hit1"},  bus.fwd_hit1,  FWD & h1);
    chk({tag, ".fwd_data1"}, bus.fwd_data1, FWD ? f1 : 64'h0);
    chk({tag, ".fwd_hit2"},  bus.fwd_hit2,  FWD & h2);
    chk({tag, ".fwd_data2"}, bus.fwd_data2, FWD ? f2 : 64'h0);
  endtask

  // One row = inputs driven in a cycle and the outputs expected in that cycle.
  typedef struct {
    logic v0; logic [4:0] rd0; logic [63:0] d0;
    logic v1; logic [4:0] rd1; logic [63:0] d1;
    logic [4:0] fa1; logic [4:0] fa2;
    logic we; logic [4:0] wa; logic [63:0] wd; logic [31:0] busy;
    logic r0; logic r1;
    logic h1; logic [63:0] f1; logic h2; logic [63:0] f2;
  } vec_t;

  vec_t vt[13];

  // Reference model state for the random phase
  bit          mv[2];
  logic [4:0]  mrd[2];
  logic [63:0] md[2];
  int          mseq[2];
  int          seqn, mlast;
  bit          pv[2];
  logic [4:0]  prd[2];
  logic [63:0] pd[2];
  logic [63:0] mbank[32], dbank[32];

  initial begin
    // contention after reset: port 0 first, port 1 next
    vt[0]  = '{1'b1,5'd3,64'h33, 1'b1,5'd4,64'h44, 5'd7,5'd9, 1'b0,5'd0,64'h0,32'h0,     1'b1,1'b1, 1'b0,64'h0,   1'b0,64'h0};
    vt[1]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd7,5'd9, 1'b1,5'd3,64'h33,32'h18,   1'b1,1'b0, 1'b0,64'h0,   1'b0,64'h0};
    vt[2]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd7,5'd9, 1'b1,5'd4,64'h44,32'h10,   1'b1,1'b1, 1'b0,64'h0,   1'b0,64'h0};
    // same-rd ordering: A (port1, older) then B (port0, younger) on r7
    vt[3]  = '{1'b1,5'd9,64'h99, 1'b1,5'd7,64'hAAAA, 5'd7,5'd9, 1'b0,5'd0,64'h0,32'h0,   1'b1,1'b1, 1'b0,64'h0,   1'b0,64'h0};
    vt[4]  = '{1'b1,5'd7,64'hBBBB, 1'b0,5'd0,64'h0, 5'd7,5'd9, 1'b1,5'd9,64'h99,32'h280, 1'b1,1'b0, 1'b1,64'hAAAA, 1'b1,64'h99};
    vt[5]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd7,5'd9, 1'b1,5'd7,64'hAAAA,32'h80, 1'b0,1'b1, 1'b1,64'hBBBB, 1'b0,64'h0};
    vt[6]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd7,5'd9, 1'b1,5'd7,64'hBBBB,32'h80, 1'b1,1'b1, 1'b1,64'hBBBB, 1'b0,64'h0};
    // single write rd=5
    vt[7]  = '{1'b1,5'd5,64'hDEAD, 1'b0,5'd0,64'h0, 5'd7,5'd9, 1'b0,5'd0,64'h0,32'h0,    1'b1,1'b1, 1'b0,64'h0,   1'b0,64'h0};
    vt[8]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd5,5'd9, 1'b1,5'd5,64'hDEAD,32'h20, 1'b1,1'b1, 1'b1,64'hDEAD, 1'b0,64'h0};
    vt[9]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd5,5'd9, 1'b0,5'd0,64'h0,32'h0,     1'b1,1'b1, 1'b0,64'h0,   1'b0,64'h0};
    // x0 write from port 1
    vt[10] = '{1'b0,5'd0,64'h0,  1'b1,5'd0,64'hFFFF, 5'd0,5'd0, 1'b0,5'd0,64'h0,32'h0,   1'b1,1'b1, 1'b0,64'h0,   1'b0,64'h0};
    vt[11] = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd0,5'd0, 1'b0,5'd0,64'hFFFF,32'h0,  1'b1,1'b1, 1'b0,64'h0,   1'b0,64'h0};
    vt[12] = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd0,5'd0, 1'b0,5'd0,64'h0,32'h0,     1'b1,1'b1, 1'b0,64'h0,   1'b0,64'h0};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    @(negedge clk);
    chk_out("reset", 1'b0, 5'd0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ---------------- table-driven directed vectors ----------------
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].v0, vt[i].rd0, vt[i].d0, vt[i].v1, vt[i].rd1, vt[i].d1, vt[i].fa1, vt[i].fa2);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), vt[i].we, vt[i].wa, vt[i].wd, vt[i].busy,
              vt[i].r0, vt[i].r1, vt[i].h1, vt[i].f1, vt[i].h2, vt[i].f2);
      @(posedge clk); #1;
    end

    // ---------------- reset asserted with both entries held ----------------
    drive(1'b1, 5'd11, 64'h1111, 1'b1, 5'd12, 64'h1212, 5'd11, 5'd12);
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 5'd11, 5'd12);
    #1;
    chk("rst_mid.pre_busy", bus.busy, 32'h1800);
    chk("rst_mid.pre_hit1", bus.fwd_hit1, FWD);
    #1 rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 5'd0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_out($sformatf("post_rst%0d", i), 1'b0, 5'd0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
      @(posedge clk); #1;
    end

    // ---------------- round-robin streaming (last_gnt fresh from reset) ----------------
    begin
      int cnt[2];
      cnt[0] = 0; cnt[1] = 0;
      for (int k = 0; k < 10; k++) begin
        logic [63:0] base1;
        int gp;
        base1 = 64'h1_0000_0000;
        drive(1'b1, 5'd10, 64'(cnt[0]), 1'b1, 5'd20, base1 + 64'(cnt[1]), 5'd0, 5'd0);
        @(negedge clk);
        if (k == 0) begin
          chk("rr0.ready0", bus.wb0_ready, 1'b1);
          chk("rr0.ready1", bus.wb1_ready, 1'b1);
          chk("rr0.we", bus.rf_we, 1'b0);
        end else begin
          gp = (k - 1) % 2;
          chk($sformatf("rr%0d.we", k), bus.rf_we, 1'b1);
          chk($sformatf("rr%0d.waddr", k), bus.rf_waddr, gp ? 5'd20 : 5'd10);
          chk($sformatf("rr%0d.wdata", k), bus.rf_wdata,
              gp ? base1 + 64'(cnt[1] - 1) : 64'(cnt[0] - 1));
          chk($sformatf("rr%0d.ready0", k), bus.wb0_ready, gp == 0);
          chk($sformatf("rr%0d.ready1", k), bus.wb1_ready, gp == 1);
        end
        if (bus.wb0_ready) cnt[0]++;
        if (bus.wb1_ready) cnt[1]++;
        @(posedge clk); #1;
      end
    end

    // ---------------- randomized run against the reference model ----------------
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 32; r++) begin mbank[r] = '0; dbank[r] = '0; end
    mv[0] = 0; mv[1] = 0; pv[0] = 0; pv[1] = 0; seqn = 0; mlast = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g;
      bit er[2];
      logic [31:0] eb;
      logic [4:0] fa[2];
      bit eh[2];
      logic [63:0] ef[2];
      for (int p = 0; p < 2; p++)
        if (!pv[p] && cyc < 380 && $urandom_range(0, 1) == 1) begin
          pv[p] = 1; prd[p] = 5'($urandom_range(0, 7)); pd[p] = {$urandom, $urandom};
        end
      fa[0] = 5'($urandom_range(0, 7));
      fa[1] = 5'($urandom_range(0, 7));
      drive(pv[0], prd[0], pd[0], pv[1], prd[1], pd[1], fa[0], fa[1]);
      @(negedge clk);
      // who the rules say gets the write port this cycle
      g = -1;
      if (mv[0] && mv[1]) begin
        if (mrd[0] == mrd[1]) g = (mseq[0] < mseq[1]) ? 0 : 1;
        else                  g = (mlast == 0) ? 1 : 0;
      end else if (mv[0]) g = 0;
      else if (mv[1])     g = 1;
      for (int p = 0; p < 2; p++) er[p] = !mv[p] || (g == p);
      eb = '0;
      for (int p = 0; p < 2; p++) if (mv[p] && mrd[p] != 0) eb[mrd[p]] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        int best;
        best = -1;
        for (int p = 0; p < 2; p++)
          if (mv[p] && mrd[p] == fa[k] && fa[k] != 0 && (best < 0 || mseq[p] > mseq[best])) best = p;
        eh[k] = (best >= 0);
        ef[k] = (best >= 0) ? md[best] : 64'h0;
      end
      chk_out($sformatf("rnd%0d", cyc),
              (g >= 0) && (mrd[g] != 0), (g >= 0) ? mrd[g] : 5'd0, (g >= 0) ? md[g] : 64'h0,
              eb, er[0], er[1], eh[0], ef[0], eh[1], ef[1]);
      if (bus.rf_we === 1'b1) dbank[bus.rf_waddr] = bus.rf_wdata;
      @(posedge clk);
      if (g >= 0) begin
        mv[g] = 0; mlast = g;
        if (mrd[g] != 0) mbank[mrd[g]] = md[g];
      end
      for (int p = 0; p < 2; p++)
        if (pv[p] && er[p]) begin
          mv[p] = 1; mrd[p] = prd[p]; md[p] = pd[p]; mseq[p] = seqn; seqn++; pv[p] = 0;
        end
      #1;
    end
    for (int r = 0; r < 8; r++) chk($sformatf("bank[%0d]", r), dbank[r], mbank[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
